led_sweep_controller: RTL and testbench

Sequencer that drives the 4-bit LED index consumed by the one-hot LED driver. It steps the index at a programmable rate in up, down, bounce or hold modes, and supports synchronous preload. It sits between board-level controls (switches/buttons) and the 16-LED one-hot decoder, and emits step and wrap pulses for downstream logic.

---
 rtl/led_sweep_if.sv | 37 +++
 rtl/led_sweep_controller.sv | 128 ++++++++++++
 tb/tb_led_sweep_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/led_sweep_if.sv
// -----------------------------------------------------------------------------
// led_sweep_if
// Purpose : Groups the control inputs and the status outputs of the LED sweep
//           sequencer into one bundle. Clock and reset are kept outside.
// Signals :
//   i_Enable     - 1 = prescaler advances, 0 = prescaler and index frozen
//   i_Mode       - 00 up, 01 down, 10 bounce, 11 hold
//   i_Load       - one-cycle strobe that preloads the index
//   i_Load_Value - value written to the index on i_Load
//   o_LED_Value  - current LED index (registered)
//   o_Dir        - current direction, 0 = up, 1 = down (registered)
//   o_Step       - one-cycle pulse when the index takes a stepped value
//   o_Wrap       - one-cycle pulse with o_Step on wrap (up/down) or reversal
// Modports:
//   master - board-side controls: drives the inputs, observes the status
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface led_sweep_if;
  logic       i_Enable;
  logic [1:0] i_Mode;
  logic       i_Load;
  logic [3:0] i_Load_Value;
  logic [3:0] o_LED_Value;
  logic       o_Dir;
  logic       o_Step;
  logic       o_Wrap;

  modport master (
    output i_Enable, i_Mode, i_Load, i_Load_Value,
    input  o_LED_Value, o_Dir, o_Step, o_Wrap
  );

  modport slave (
    input  i_Enable, i_Mode, i_Load, i_Load_Value,
    output o_LED_Value, o_Dir, o_Step, o_Wrap
  );
endinterface

// File: rtl/led_sweep_controller.sv
// -----------------------------------------------------------------------------
// led_sweep_controller
// Purpose : Steps a 4-bit LED index at a programmable rate in up, down,
//           bounce or hold mode, with synchronous preload. Emits a one-cycle
//           step pulse with every index step and a wrap pulse when the step
//           wraps (up/down) or reverses (bounce).
// Parameters:
//   CLKS_PER_STEP - clock cycles between index steps (>= 1)
// Ports:
//   i_Clk   - system clock, rising edge
//   i_Reset - synchronous, active-high reset
//   bus     - control/status bundle (led_sweep_if.slave)
// -----------------------------------------------------------------------------
module led_sweep_controller #(
  parameter int unsigned CLKS_PER_STEP = 25_000_000
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  led_sweep_if.slave     bus
);

  localparam int unsigned PW = (CLKS_PER_STEP <= 1) ? 1 : $clog2(CLKS_PER_STEP);
  localparam int unsigned TERM_INT = (CLKS_PER_STEP == 0) ? 0 : CLKS_PER_STEP - 1;
  localparam logic [PW-1:0] TERM = TERM_INT[PW-1:0];

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    led_q, led_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;

  logic          advance_s;
  logic          terminal_s;

  // Prescaler only runs when enabled and not in hold; the terminal edge is the
  // one where it already holds the last count.
  always_comb begin
    advance_s  = bus.i_Enable && (bus.i_Mode != MODE_HOLD);
    terminal_s = advance_s && (presc_q == TERM);
  end

  // Next-state logic: load beats a coincident terminal edge, pulses default low.
  always_comb begin
    presc_d = presc_q;
    led_d   = led_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.i_Load) begin
      led_d   = bus.i_Load_Value;
      presc_d = '0;
    end else if (terminal_s) begin
      presc_d = '0;
      step_d  = 1'b1;
      case (bus.i_Mode)
        MODE_UP: begin
          led_d  = led_q + 4'd1;
          dir_d  = 1'b0;
          wrap_d = (led_q == 4'd15);
        end
        MODE_DOWN: begin
          led_d  = led_q - 4'd1;
          dir_d  = 1'b1;
          wrap_d = (led_q == 4'd0);
        end
        MODE_BOUNCE: begin
          // Bounce continues in whatever direction is currently held.
          if (!dir_q) begin
            if (led_q == 4'd15) begin
              led_d  = 4'd14;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              led_d  = led_q + 4'd1;
            end
          end else begin
            if (led_q == 4'd0) begin
              led_d  = 4'd1;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else begin
              led_d  = led_q - 4'd1;
            end
          end
        end
        default: begin
          // Hold never produces a terminal edge; keep state as a safe fallback.
          led_d  = led_q;
          dir_d  = dir_q;
          step_d = 1'b0;
          wrap_d = 1'b0;
        end
      endcase
    end else if (advance_s) begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      presc_d = presc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q <= '0;
      led_q   <= 4'd0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.o_LED_Value = led_q;
  assign bus.o_Dir       = dir_q;
  assign bus.o_Step      = step_q;
  assign bus.o_Wrap      = wrap_q;

endmodule

// File: tb/tb_led_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_led_sweep_controller
// Purpose : Directed bench for led_sweep_controller with CLKS_PER_STEP = 4.
//           Inputs change 1 time unit after a rising edge and outputs are
//           sampled at that point, so each tick() covers exactly one edge.
// -----------------------------------------------------------------------------
module tb_led_sweep_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  led_sweep_if u_if ();

  led_sweep_controller #(.CLKS_PER_STEP(4)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (u_if.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] led, input logic dir,
                         input logic stp, input logic wrp);
    check({tag, ".led"},  {28'd0, u_if.o_LED_Value}, {28'd0, led});
    check({tag, ".dir"},  {31'd0, u_if.o_Dir},       {31'd0, dir});
    check({tag, ".step"}, {31'd0, u_if.o_Step},      {31'd0, stp});
    check({tag, ".wrap"}, {31'd0, u_if.o_Wrap},      {31'd0, wrp});
  endtask

  // Expected bounce sequence starting from a load of 13 with dir = 0.
  logic [3:0] b_led  [18] = '{4'd14, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
                              4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd0, 4'd1};
  logic       b_dir  [18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       b_wrap [18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    u_if.i_Enable     = 1'b0;
    u_if.i_Mode       = 2'b00;
    u_if.i_Load       = 1'b0;
    u_if.i_Load_Value = 4'd0;

    // Reset state
    tick();
    tick();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Up sweep: step every 4th edge, wrap on the 64th
    rst = 1'b0;
    u_if.i_Enable = 1'b1;
    u_if.i_Mode   = 2'b00;
    for (int e = 1; e <= 64; e++) begin
      tick();
      chk_all("up", 4'((e / 4) % 16), 1'b0, (e % 4) == 0, e == 64);
    end

    // Down wrap: load 2 then 1, 0, 15
    u_if.i_Load       = 1'b1;
    u_if.i_Load_Value = 4'd2;
    u_if.i_Mode       = 2'b01;
    tick();
    u_if.i_Load = 1'b0;
    chk_all("down_load", 4'd2, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_all("down", (e < 4) ? 4'd2 : (e < 8) ? 4'd1 : (e < 12) ? 4'd0 : 4'd15,
              e >= 4, (e % 4) == 0, e == 12);
    end

    // Bounce from 13 with dir = 0 (reset to clear dir)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_if.i_Load       = 1'b1;
    u_if.i_Load_Value = 4'd13;
    u_if.i_Mode       = 2'b10;
    tick();
    u_if.i_Load = 1'b0;
    chk_all("bounce_load", 4'd13, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 18; s++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check("bounce.idle_step", {31'd0, u_if.o_Step}, 32'd0);
      end
      tick();
      chk_all("bounce", b_led[s], b_dir[s], 1'b1, b_wrap[s]);
    end

    // Load on terminal edge: prescaler is 0 after the last step, 3 ticks -> 3
    u_if.i_Mode = 2'b00;
    tick();
    tick();
    tick();
    u_if.i_Load       = 1'b1;
    u_if.i_Load_Value = 4'd9;
    tick();
    u_if.i_Load = 1'b0;
    chk_all("load_term", 4'd9, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk_all("after_load", (e == 4) ? 4'd10 : 4'd9, 1'b0, e == 4, 1'b0);
    end

    // Freeze: 1 counted edge, 3 disabled, 5 in hold, then 3 more to the step
    tick();
    chk_all("freeze_pre", 4'd10, 1'b0, 1'b0, 1'b0);
    u_if.i_Enable = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk_all("freeze_dis", 4'd10, 1'b0, 1'b0, 1'b0);
    end
    u_if.i_Enable = 1'b1;
    u_if.i_Mode   = 2'b11;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_all("freeze_hold", 4'd10, 1'b0, 1'b0, 1'b0);
    end
    u_if.i_Mode = 2'b00;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_all("freeze_resume", (e == 3) ? 4'd11 : 4'd10, 1'b0, e == 3, 1'b0);
    end

    // Reset mid-run: reach index 7, dir 1, prescaler 2
    u_if.i_Load       = 1'b1;
    u_if.i_Load_Value = 4'd8;
    u_if.i_Mode       = 2'b01;
    tick();
    u_if.i_Load = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    chk_all("pre_reset", 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk_all("post_reset", (e == 4) ? 4'd15 : 4'd0, e == 4, e == 4, e == 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
